lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencing controller for the RV32I data-memory port; sits between the MEM pipeline stage and the data memory.
- Accepts one load/store request per handshake and checks its alignment and fun3.
- Drives a single-outstanding request/grant/rvalid memory transaction with byte-lane steering and load sign/zero extension.
- Returns a one-cycle response to the pipeline. Any illegal access or memory timeout is reported as an error.

Parameters:
- DataWidth, 32, data/address width; only 32 is supported.
- Timeout, 64, maximum WAIT cycles before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_fun3  in  3  RV32I funct3 of the access.
- req_addr  in  DataWidth  byte address.
- req_wdata  in  DataWidth  store data, right-aligned.
- mem_req  out  1  memory request valid.
- mem_gnt  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  DataWidth  word address, {req_addr[31:2], 2'b00}.
- mem_mask  out  4  byte-lane write strobes.
- mem_wdata  out  DataWidth  lane-steered store data.
- mem_rvalid  in  1  read data or write acknowledge is valid.
- mem_rdata  in  DataWidth  raw read word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  misaligned, illegal or timed-out access; qualified by rsp_valid.
- rsp_rdata  out  DataWidth  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE; timeout counter = 0.
  - mem_req, mem_we, mem_mask, mem_wdata, mem_addr, rsp_valid, rsp_err, rsp_rdata all 0.
  - Reset mid-transaction abandons the transaction. A late mem_gnt or mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready = 1 only in IDLE. A request is accepted when req_valid & req_ready; address, fun3, we and wdata are captured into registers.
- Legality check at acceptance:
  - Legal load fun3: 000, 001, 010, 100, 101.
  - Legal store fun3: 000, 001, 010.
  - Halfword is misaligned iff addr[1:0] = 3.
  - Word is misaligned iff addr[1:0] != 0.
  - Illegal or misaligned: go to RESP with rsp_err = 1; no memory access is issued.
- IDLE -> REQ on a legal accept.
- REQ:
  - mem_req = 1; all mem_* outputs held stable until mem_gnt.
  - On mem_gnt: stores go to RESP; loads go to WAIT.
  - mem_rvalid is ignored in REQ. Memory returns rvalid at least 1 cycle after gnt.
- Store lane steering, with b = addr[1:0]:
  - sb: mask = 1 << b; the byte is replicated into lane b.
  - sh: mask = 0011, 0110 or 1100 for b = 0, 1, 2; the halfword is placed at byte b.
  - sw: mask = 1111; data passed through unchanged.
  - Unused lanes of mem_wdata are don't-care but driven deterministically as the replicated value.
- WAIT:
  - The counter increments each cycle. On mem_rvalid, the extended data is captured and the FSM goes to RESP.
  - If Timeout != 0 and the counter reaches Timeout without rvalid: go to RESP with rsp_err = 1.
  - rvalid and the timeout in the same cycle: rvalid wins.
- Load extension:
  - lb/lbu take byte b; lh/lhu take bytes b+1:b; lw takes the whole word.
  - lb/lh are sign-extended; lbu/lhu are zero-extended.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. The counter is cleared on leaving WAIT.
- Latency with immediate grant and rvalid:
  - Store: accept at cycle 0, mem_req at cycle 1, rsp_valid at cycle 2.
  - Load: accept at cycle 0, gnt at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
  - Error: accept at cycle 0, rsp_valid at cycle 1.
- Back-to-back operation: the next request can be accepted in the cycle after RESP.

Decomposition:
- Package lsu_pkg:
  - fun3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_e {IDLE, REQ, WAIT, RESP}.
  - Lane-mask constants.
- Sub-module lsu_lane:
  - Purely combinational: (fun3, byteadd, wdata, rdata) -> (mask, steered wdata, extended rdata, misaligned flag).
  - lsu_ctrl holds the FSM, capture registers and timeout counter.

Test Plan:
- sb at addr 0x103, wdata 0x000000A5, gnt in the first REQ cycle -> mem_addr 0x100, mem_mask 1000, mem_wdata[31:24] = 0xA5, rsp_valid at cycle 2, rsp_err 0.
- lh at addr 0x202, mem_rdata 0x8001_1234, rvalid 3 cycles after gnt -> rsp_rdata 0xFFFF8001; lhu at the same address -> 0x00008001.
- lw at addr 0x301 -> no mem_req; rsp_valid at cycle 1 with rsp_err 1. sh at byteadd 3, and load fun3 011, give the same error result.
- lw with gnt held low 5 cycles -> mem_req and mem_addr stable for all 5 cycles. With Timeout = 4 and no rvalid, rsp_err = 1 exactly 4 cycles after entering WAIT.
- rst_n low during WAIT, then rvalid arrives 1 cycle after release -> state IDLE, no rsp_valid, req_ready 1.
- Back-to-back sw/lw with req_valid held high -> second accept in the cycle after the first rsp_valid; no request is lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I funct3 encodings for data accesses, the controller state
// encoding, byte-lane mask constants and the funct3 legality helper.
package lsu_pkg;

  // RV32I load/store funct3 encodings (stores use only B/H/W).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Lane masks for an access starting at byte 0; shifted by the byte offset.
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic fun3_legal(input logic we, input logic [2:0] fun3);
    if (we) return (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W);
    return (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W) ||
           (fun3 == F3_BU) || (fun3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the load/store unit.
// Single-outstanding request/grant/rvalid bus.
//   master : the controller (drives req/we/addr/mask/wdata)
//   slave  : the memory     (drives gnt/rvalid/rdata)
interface lsu_ctrl_if #(
  parameter int DataWidth = 32
);
  logic                 mem_req;
  logic                 mem_gnt;
  logic                 mem_we;
  logic [DataWidth-1:0] mem_addr;
  logic [3:0]           mem_mask;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_rvalid;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_mask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_mask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering for one 32-bit data access (purely combinational).
//   fun3/byteadd    : access size/signedness and byte offset in the word
//   wdata           : right-aligned store data
//   rdata           : raw word returned by memory
//   mask            : byte-lane write strobes
//   wdata_out       : store data replicated so the target lanes carry it
//   rdata_out       : load data shifted down and sign/zero extended
//   misaligned      : access crosses a word boundary for its size
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  fun3,
  input  logic [1:0]  byteadd,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misaligned
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    mask       = MASK_NONE;
    wdata_out  = wdata;
    rdata_out  = rdata;
    misaligned = 1'b0;
    rshift     = rdata >> {byteadd, 3'b000};
    rbyte      = rshift[7:0];
    rhalf      = rshift[15:0];

    // fun3[2] selects zero extension; fun3[1:0] is the access size.
    case (fun3[1:0])
      2'b00: begin
        mask      = MASK_B << byteadd;
        wdata_out = {4{wdata[7:0]}};
        rdata_out = fun3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      2'b01: begin
        misaligned = (byteadd == 2'd3);
        mask       = MASK_H << byteadd;
        // Offset 1 needs the halfword in bytes 2:1; the other lanes get
        // the wrapped-around copy so every lane is deterministic.
        wdata_out  = (byteadd == 2'd1) ? {wdata[7:0], wdata[15:0], wdata[15:8]}
                                       : {2{wdata[15:0]}};
        rdata_out  = fun3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      2'b10: begin
        misaligned = (byteadd != 2'd0);
        mask       = MASK_W;
      end
      default: begin
        // Size 11 is illegal for RV32I; legality is rejected elsewhere.
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller between the MEM stage and data memory.
//   clk, rst_n       : clock, synchronous active-low reset
//   req_*            : pipeline request (valid/ready handshake)
//   mem              : memory port (lsu_ctrl_if master modport)
//   rsp_valid/err    : one-cycle response pulse and error qualifier
//   rsp_rdata        : extended load data, 0 for stores and errors
//   busy             : controller is not idle
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Timeout   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_fun3,
  input  logic [DataWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  lsu_ctrl_if.master           mem,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 busy
);

  // The counter only needs to hold 0 .. Timeout-1.
  localparam int CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((Timeout > 0) ? Timeout - 1 : 0);

  lsu_state_e           state_q, state_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [2:0]           fun3_q, fun3_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [2:0]           lane_fun3;
  logic [1:0]           lane_byte;
  logic [3:0]           lane_mask;
  logic [31:0]          lane_wdata;
  logic [31:0]          lane_rdata;
  logic                 lane_misaligned;

  // In IDLE the lane logic looks at the incoming request so the alignment
  // check is available at acceptance; otherwise it works on the captured
  // access, which keeps the memory outputs stable while waiting.
  assign lane_fun3 = (state_q == IDLE) ? req_fun3 : fun3_q;
  assign lane_byte = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_lane u_lane (
    .fun3       (lane_fun3),
    .byteadd    (lane_byte),
    .wdata      (wdata_q),
    .rdata      (mem.mem_rdata),
    .mask       (lane_mask),
    .wdata_out  (lane_wdata),
    .rdata_out  (lane_rdata),
    .misaligned (lane_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fun3_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fun3_q  <= fun3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fun3_d  = fun3_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fun3_d  = req_fun3;
          we_d    = req_we;
          rdata_d = '0;
          if (!fun3_legal(req_we, req_fun3) || lane_misaligned) begin
            // Rejected accesses never reach memory.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        // rvalid takes priority over an expiring timeout in the same cycle.
        if (mem.mem_rvalid) begin
          rdata_d = lane_rdata;
          cnt_d   = '0;
          state_d = RESP;
        end else if ((Timeout != 0) && (cnt_q == CntLast)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = (state_q == REQ) && we_q;
  assign mem.mem_addr  = {addr_q[DataWidth-1:2], 2'b00};
  assign mem.mem_mask  = mem.mem_we ? lane_mask : MASK_NONE;
  assign mem.mem_wdata = (state_q == REQ) ? lane_wdata : '0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule
